// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
//
// Contents:
//   FN_*        function select, carried on S[3:2]
//   BS_*        B-operand select, carried on S[1:0]
//   OP_SUB/INC  complete 4-bit codes for the common derived operations
//   seq_state_e sequencer FSM states
package alu_pkg;

    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_ADD = 2'b11;

    localparam logic [1:0] BS_ZERO = 2'b00;
    localparam logic [1:0] BS_ONE  = 2'b01;
    localparam logic [1:0] BS_B    = 2'b10;
    localparam logic [1:0] BS_NB   = 2'b11;

    // SUB is A + ~B + 1, INC is A + 0 + 1; both need cin = 1.
    localparam logic [3:0] OP_SUB = {FN_ADD, BS_NB};
    localparam logic [3:0] OP_INC = {FN_ADD, BS_ZERO};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_serial_shreg.sv
// WIDTH-bit load / shift-right register with serial input and parallel output.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active-high, clears the register
//   load      parallel load of load_val (takes priority over shift)
//   load_val  value loaded on load
//   shift     shift right by one, ser_in enters at the MSB
//   ser_in    serial input bit
//   q         parallel register contents (q[0] is the next bit out)
module alu_serial_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (shift) begin
            q_d = {ser_in, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for the 1-bit ALU slice. Accepts one WIDTH-bit
// operation, feeds the operands LSB-first into the slice over WIDTH cycles
// while chaining the carry through a flop, and returns the assembled result
// word with carry and zero flags.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     operation handshake (in_a, in_b, in_op, in_cin)
//   alu_a/b/cin/s         slice inputs, driven only while running, else 0
//   alu_f/alu_cout        slice outputs (combinational from alu_*)
//   out_valid/out_ready   result handshake (out_f, out_cout, out_zero)
//   out_ovf               signed overflow flag (only with ALU_SERIAL_OVF_EN)
//
// Build option: define ALU_SERIAL_OVF_EN to add the out_ovf port and flop.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_cin,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_s,
    input  logic             alu_f,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_zero
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    seq_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             running;
    logic             last_bit;

    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] res_word;

    // Only bit 0 of the operand shifters ever feeds the slice.
    logic             unused_operand_hi;
    assign unused_operand_hi = ^{a_word[WIDTH-1:1], b_word[WIDTH-1:1]};

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign running  = (state_q == ST_RUN);
    assign last_bit = running && (cnt_q == CNT_W'(WIDTH - 1));

    // Operand shifters: loaded on accept, bit 0 consumed each RUN cycle.
    alu_serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (in_a),
        .shift    (running),
        .ser_in   (1'b0),
        .q        (a_word)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (in_b),
        .shift    (running),
        .ser_in   (1'b0),
        .q        (b_word)
    );

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at bit 0.
    alu_serial_shreg #(.WIDTH(WIDTH)) u_res_sh (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val ('0),
        .shift    (running),
        .ser_in   (alu_f),
        .q        (res_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Carry chains through carry_q; for logic functions the slice reports
    // cout = whatever it likes, and out_cout masks it in DONE.
    always_comb begin
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            op_d    = in_op;
            carry_d = in_cin;
            cnt_d   = '0;
        end else if (running) begin
            carry_d = alu_cout;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is carry_q during the last bit; XOR with carry out.
    always_comb begin
        ovf_d = ovf_q;
        if (last_bit) begin
            ovf_d = alu_cout ^ carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cin   = 1'b0;
        alu_s     = '0;
        out_f     = '0;
        out_cout  = 1'b0;
        out_zero  = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
        out_ovf   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                alu_a   = a_word[0];
                alu_b   = b_word[0];
                alu_cin = carry_q;
                alu_s   = op_q;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_f     = res_word;
                out_cout  = (op_q[3:2] == FN_ADD) ? carry_q : 1'b0;
                out_zero  = ~|res_word;
`ifdef ALU_SERIAL_OVF_EN
                out_ovf   = (op_q[3:2] == FN_ADD) ? ovf_q : 1'b0;
`endif
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
